// File: rtl/seq_shifter_32.sv
// Sequential 32-bit shifter: one bit of shift per clock, ShiftAmount cycles in RUN.
// Modes: 0 LSL, 1 ROL, 2 LSR, 3 ASR, 4 ROR, 5-7 pass-through.
// Optional feature macro: SHIFTER_ROTATE_EN enables ROL/ROR. Without it, modes 1
// and 4 are pass-through with unchanged latency, and no rotate logic is built.
module seq_shifter_32 #(
  parameter logic [31:0] ResultInit = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] DataA,
  input  logic [4:0]  ShiftAmount,
  input  logic [2:0]  Mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result
);

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Run  = 2'd1,
    Done = 2'd2
  } stateT;

  typedef enum logic [2:0] {
    OpLsl = 3'd0,
    OpRol = 3'd1,
    OpLsr = 3'd2,
    OpAsr = 3'd3,
    OpRor = 3'd4
  } opT;

  stateT       state;
  logic [31:0] workReg;
  logic [31:0] shifted;
  logic [4:0]  count;
  logic [2:0]  modeReg;

  // Single-bit step of the working register according to the captured mode.
  always_comb begin
    shifted = workReg;
    case (modeReg)
      OpLsl:   shifted = {workReg[30:0], 1'b0};
      OpLsr:   shifted = {1'b0, workReg[31:1]};
      OpAsr:   shifted = {workReg[31], workReg[31:1]};
`ifdef SHIFTER_ROTATE_EN
      OpRol:   shifted = {workReg[30:0], workReg[31]};
      OpRor:   shifted = {workReg[0], workReg[31:1]};
`endif
      default: shifted = workReg;
    endcase
  end

  // Control FSM with registered busy/done/Result; reset wins over start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= Idle;
      busy    <= 1'b0;
      done    <= 1'b0;
      Result  <= ResultInit;
      count   <= '0;
      workReg <= '0;
      modeReg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        Idle: begin
          if (start) begin
            workReg <= DataA;
            count   <= ShiftAmount;
            modeReg <= Mode;
            busy    <= 1'b1;
            state   <= Run;
          end
        end
        Run: begin
          if (count != '0) begin
            workReg <= shifted;
            count   <= count - 5'd1;
          end else begin
            Result <= workReg;
            done   <= 1'b1;
            state  <= Done;
          end
        end
        Done: begin
          busy  <= 1'b0;
          state <= Idle;
        end
        default: begin
          busy  <= 1'b0;
          state <= Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter_32.sv
// Self-checking bench for seq_shifter_32: behavioural model plus directed literal cases.
// Honours SHIFTER_ROTATE_EN the same way as the design.
module tb_seq_shifter_32;

  localparam logic [31:0] Init = 32'hA5A5_0F0F;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] DataA;
  logic [4:0]  ShiftAmount;
  logic [2:0]  Mode;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 0;

  seq_shifter_32 #(.ResultInit(Init)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .DataA       (DataA),
    .ShiftAmount (ShiftAmount),
    .Mode        (Mode),
    .busy        (busy),
    .done        (done),
    .Result      (Result)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-operation result from plain arithmetic on the operands.
  function automatic logic [31:0] expectedResult(input logic [31:0] a, input logic [4:0] n,
                                                  input logic [2:0] m);
    logic [31:0] r;
    int          sh;
    sh = int'(n);
    case (m)
      3'd0: r = a << sh;
      3'd2: r = a >> sh;
      3'd3: r = $signed(a) >>> sh;
`ifdef SHIFTER_ROTATE_EN
      3'd1: r = (a << sh) | (a >> (32 - sh));
      3'd4: r = (a >> sh) | (a << (32 - sh));
`endif
      default: r = a;
    endcase
    return r;
  endfunction

  // Model: an accepted op finishes N+1 edges later, then one DONE cycle.
  bit          mBusy   = 0;
  bit          mDone   = 0;
  logic [31:0] mResult = Init;
  logic [31:0] pendRes = '0;
  int          remain  = 0;

  always @(posedge clock) begin
    if (reset) begin
      mBusy   = 0;
      mDone   = 0;
      mResult = Init;
      remain  = 0;
    end else begin
      mDone = 0;
      if (!mBusy) begin
        if (start) begin
          mBusy   = 1;
          pendRes = expectedResult(DataA, ShiftAmount, Mode);
          remain  = int'(ShiftAmount) + 1;
        end
      end else if (remain == 0) begin
        mBusy = 0;
      end else begin
        remain--;
        if (remain == 0) begin
          mDone   = 1;
          mResult = pendRes;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model.
  always @(negedge clock) begin
    if (checkEn) begin
      chk("model_busy", {31'd0, busy}, {31'd0, mBusy});
      chk("model_done", {31'd0, done}, {31'd0, mDone});
      chk("model_result", Result, mResult);
    end
  end

  task automatic randomInputs();
    DataA       = $urandom();
    ShiftAmount = 5'($urandom_range(0, 31));
    Mode        = 3'($urandom_range(0, 7));
  endtask

  // One pulsed op with scrambled inputs afterwards; checks latency, busy span, result.
  task automatic doOp(input string name, input logic [31:0] a, input logic [4:0] n,
                      input logic [2:0] m, input logic [31:0] exp);
    int edges;
    int busyCnt;
    @(negedge clock);
    start = 1'b1; DataA = a; ShiftAmount = n; Mode = m;
    @(negedge clock);
    start = 1'b0;
    randomInputs();
    edges   = 0;
    busyCnt = int'(busy);
    do begin
      @(negedge clock);
      edges++;
      busyCnt += int'(busy);
    end while (!done && edges < 40);
    chk({name, "_latency"}, 32'(edges), 32'(int'(n) + 1));
    chk({name, "_result"}, Result, exp);
    @(negedge clock);
    chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_busy_cycles"}, 32'(busyCnt), 32'(int'(n) + 2));
  endtask

  initial begin
    int dIdx;
    reset = 1'b1; start = 1'b0; DataA = '0; ShiftAmount = '0; Mode = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkEn = 1;
    chk("reset_result", Result, 32'hA5A5_0F0F);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    doOp("lsl4", 32'h0000_0001, 5'd4, 3'd0, 32'h0000_0010);
    doOp("asr31", 32'h8000_0000, 5'd31, 3'd3, 32'hFFFF_FFFF);
    doOp("lsr31", 32'h8000_0000, 5'd31, 3'd2, 32'h0000_0001);
`ifdef SHIFTER_ROTATE_EN
    doOp("rol1", 32'h8000_0001, 5'd1, 3'd1, 32'h0000_0003);
    doOp("ror1", 32'h8000_0001, 5'd1, 3'd4, 32'hC000_0000);
`else
    doOp("rol1", 32'h8000_0001, 5'd1, 3'd1, 32'h8000_0001);
    doOp("ror1", 32'h8000_0001, 5'd1, 3'd4, 32'h8000_0001);
`endif
    doOp("n0_lsr", 32'hDEAD_BEEF, 5'd0, 3'd2, 32'hDEAD_BEEF);
    doOp("pass6", 32'h1234_5678, 5'd3, 3'd6, 32'h1234_5678);
    doOp("lsl_edge", 32'hFFFF_FFFF, 5'd31, 3'd0, 32'h8000_0000);

    // start held high with inputs changing every cycle
    dIdx = -1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      if (i == 5) chk("hold_result", Result, 32'h0000_001E);
      if (i == 6) chk("hold_idle_busy", {31'd0, busy}, 32'd0);
      if (i == 7) chk("hold_reaccept_busy", {31'd0, busy}, 32'd1);
      if (done && dIdx < 0) dIdx = i;
      start = 1'b1;
      if (i == 0) begin
        DataA = 32'h0000_00F0; ShiftAmount = 5'd3; Mode = 3'd2;
      end else begin
        randomInputs();
      end
    end
    chk("hold_done_cycle", 32'(dIdx), 32'd5);
    start = 1'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clock);
    chk("hold_drain", {31'd0, busy}, 32'd0);

    // abort: reset asserted during an N=10 run
    @(negedge clock);
    start = 1'b1; DataA = 32'h0000_0001; ShiftAmount = 5'd10; Mode = 3'd0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_result", Result, 32'hA5A5_0F0F);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    dIdx = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      dIdx += int'(done);
    end
    chk("abort_no_done", 32'(dIdx), 32'd0);

    // reset has priority over start
    @(negedge clock);
    reset = 1'b1; start = 1'b1;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    chk("reset_prio_busy", {31'd0, busy}, 32'd0);

    // randomized traffic, occasional reset
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      start = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 299) == 0);
      randomInputs();
      if ($urandom_range(0, 3) == 0) ShiftAmount = 5'($urandom_range(0, 2));
    end
    start = 1'b0; reset = 1'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clock);
    chk("final_idle", {31'd0, busy}, 32'd0);

    @(negedge clock);
    checkEn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
